// File: rtl/commit_trace_buf_pkg.sv
// Shared types and widths for the commit trace buffer: entry payload, FSM states
// and halt cause encodings.
package commit_trace_buf_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DROP_W = 16;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [ILEN-1:0]  instr;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  wdata;
  } trace_entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE = 2'b00,
    HC_PC   = 2'b01,
    HC_CYC  = 2'b10,
    HC_BOTH = 2'b11
  } halt_cause_e;

endpackage

// File: rtl/commit_trace_buf_if.sv
// Commit-side input and drain-side valid/ready output of the trace buffer.
interface commit_trace_buf_if;
  import commit_trace_buf_pkg::*;

  logic              cm_valid;
  logic [XLEN-1:0]   cm_pc;
  logic [ILEN-1:0]   cm_instr;
  logic              cm_regwrite;
  logic [REG_W-1:0]  cm_rd;
  logic [XLEN-1:0]   cm_wdata;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [ILEN-1:0]   out_instr;
  logic [REG_W-1:0]  out_rd;
  logic [XLEN-1:0]   out_wdata;

  modport master (
    output cm_valid, cm_pc, cm_instr, cm_regwrite, cm_rd, cm_wdata, out_ready,
    input  out_valid, out_pc, out_instr, out_rd, out_wdata
  );

  modport slave (
    input  cm_valid, cm_pc, cm_instr, cm_regwrite, cm_rd, cm_wdata, out_ready,
    output out_valid, out_pc, out_instr, out_rd, out_wdata
  );

endinterface

// File: rtl/commit_trace_buf_fifo.sv
// First-word-fall-through FIFO of trace entries with a registered head; optional
// overwrite-oldest behaviour when full.
module commit_trace_buf_fifo
  import commit_trace_buf_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter bit          RING_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output trace_entry_t dout,
  output logic         valid,
  output logic         drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  trace_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic          empty_c, full_c, do_pop, we, nxt_empty;
  logic [AW-1:0] nxt_idx;
  trace_entry_t  dout_d;

  // Next pointers; the head register is preloaded with whatever entry sits at the new head.
  always_comb begin
    wr_d      = wr_q;
    rd_d      = rd_q;
    we        = 1'b0;
    drop_c    = 1'b0;
    dout_d    = '0;
    empty_c   = (wr_q == rd_q);
    full_c    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    do_pop    = pop && !empty_c;

    if (do_pop) rd_d = rd_q + PW'(1);
    if (push) begin
      if (!full_c || do_pop) begin
        we   = 1'b1;
        wr_d = wr_q + PW'(1);
      end else if (RING_MODE) begin
        we     = 1'b1;
        wr_d   = wr_q + PW'(1);
        rd_d   = rd_q + PW'(1);
        drop_c = 1'b1;
      end else begin
        drop_c = 1'b1;
      end
    end

    nxt_empty = (wr_d == rd_d);
    nxt_idx   = rd_d[AW-1:0];
    if (!nxt_empty) begin
      if (we && (wr_q[AW-1:0] == nxt_idx)) dout_d = din;
      else                                 dout_d = mem[nxt_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      valid <= !nxt_empty;
      dout  <= dout_d;
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (we && !clear) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Retire-trace capture: buffers committed instructions, freezes on HALT_PC or cycle
// budget, and lets a host drain entries over valid/ready.
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     CNT_W      = 32,
  parameter logic [XLEN-1:0] HALT_PC    = XLEN'(32'h314),
  parameter int unsigned     MAX_CYCLES = 1000,
  parameter bit              RING_MODE  = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  commit_trace_buf_if.slave bus,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam bit              CYC_EN    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES - 1);

  state_e       state_q;
  logic         run, hit_pc, hit_cyc, push, fifo_drop;
  trace_entry_t entry, head;

  // Halt detection and capture payload; rd/wdata are zeroed for non-writing instructions.
  always_comb begin
    run         = (state_q == ST_RUN);
    hit_pc      = run && bus.cm_valid && (bus.cm_pc == HALT_PC);
    hit_cyc     = run && CYC_EN && (cycle_cnt == CYC_LIMIT);
    push        = run && bus.cm_valid;
    entry.pc    = bus.cm_pc;
    entry.instr = bus.cm_instr;
    entry.rd    = bus.cm_regwrite ? bus.cm_rd    : '0;
    entry.wdata = bus.cm_regwrite ? bus.cm_wdata : '0;
  end

  commit_trace_buf_fifo #(
    .DEPTH     (DEPTH),
    .RING_MODE (RING_MODE)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (clear),
    .push   (push),
    .din    (entry),
    .pop    (bus.out_ready),
    .dout   (head),
    .valid  (bus.out_valid),
    .drop_c (fifo_drop)
  );

  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.out_rd    = head.rd;
  assign bus.out_wdata = head.wdata;

  // Run/halt FSM with saturating counters; the halting cycle itself is not counted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_RUN;
      halted     <= 1'b0;
      halt_cause <= HC_NONE;
      cycle_cnt  <= '0;
      drop_cnt   <= '0;
    end else if (clear) begin
      state_q    <= ST_RUN;
      halted     <= 1'b0;
      halt_cause <= HC_NONE;
      cycle_cnt  <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fifo_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
          if (hit_pc || hit_cyc) begin
            state_q <= ST_HALTED;
            halted  <= 1'b1;
            if (hit_pc && hit_cyc) halt_cause <= HC_BOTH;
            else if (hit_pc)       halt_cause <= HC_PC;
            else                   halt_cause <= HC_CYC;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

endmodule
